// File: rtl/pe_seq_pkg.sv
// rtl/pe_seq_pkg.sv - states, uop struct and uop encodings for pe_seq
`include "defines.sv"

package pe_seq_pkg;

    localparam int XLEN = `XLEN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_MAC,
        S_BIAS,
        S_RELU,
        S_OUT,
        S_DRAIN
    } state_t;

    // Bit order matches the 5-bit uop word understood by the pe.
    typedef struct packed {
        logic flush;
        logic in_valid;
        logic calc_bias;
        logic calc_relu;
        logic out_en;
    } uop_t;

    localparam logic [4:0] UOP_NOP    = 5'b00000;
    localparam logic [4:0] UOP_FLUSH  = 5'b10000;
    localparam logic [4:0] UOP_MAC    = 5'b01000;
    localparam logic [4:0] UOP_BIAS   = 5'b01100;
    localparam logic [4:0] UOP_RELU   = 5'b00010;
    localparam logic [4:0] UOP_OUT_EN = 5'b00001;

    // Attach out_en to a base uop when it is the final uop of the job.
    function automatic uop_t mk_uop(input logic [4:0] enc, input logic last);
        return uop_t'(enc | {4'b0000, last});
    endfunction

endpackage

// File: rtl/defines.sv
// rtl/defines.sv - shared datapath width macros for the pe lane
`ifndef PE_DEFINES_SV
`define PE_DEFINES_SV

`define XLEN 32
`define DATA_RANGE (`XLEN-1):0

`endif

// File: rtl/pe_seq.sv
// rtl/pe_seq.sv - dot-product job sequencer driving a single pe
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_*                 job command (len, bias enable, relu enable, bias value)
//   op_valid/op_ready     operand pair stream (op_x, op_w)
//   pe_*  (out)           uop bits and data buses into the pe
//   pe_result, pe_out_valid, pe_illegal_uop  status from the pe
//   res_valid/res_ready   result handshake to the consumer (res_data)
//   err                   sticky illegal-uop flag, cleared on command accept
`include "defines.sv"

module pe_seq
    import pe_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CNT_W-1:0]    cmd_len,
    input  logic                cmd_bias,
    input  logic                cmd_relu,
    input  logic [`DATA_RANGE]  cmd_bias_val,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [`DATA_RANGE]  op_x,
    input  logic [`DATA_RANGE]  op_w,
    output logic [`DATA_RANGE]  pe_x,
    output logic [`DATA_RANGE]  pe_weight,
    output logic                pe_in_valid,
    output logic                pe_flush,
    output logic                pe_out_en,
    output logic                pe_calc_bias,
    output logic                pe_calc_relu,
    input  logic [`DATA_RANGE]  pe_result,
    input  logic                pe_out_valid,
    input  logic                pe_illegal_uop,
    output logic                res_valid,
    output logic [`DATA_RANGE]  res_data,
    input  logic                res_ready,
    output logic                err
);

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     cnt;
    logic                 bias_q;
    logic                 relu_q;
    logic [`DATA_RANGE]   bias_val_q;
    uop_t                 uop;
    logic                 accept;
    logic                 last_beat;

    assign accept    = cmd_valid && cmd_ready;
    assign last_beat = (cnt == CNT_W'(1));

    // Uops follow op_valid in the same cycle so a stalled operand stream
    // leaves the pe idle rather than inserting a bubble after each beat.
    always_comb begin
        uop        = uop_t'(UOP_NOP);
        pe_x       = '0;
        pe_weight  = '0;
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) next_state = S_FLUSH;
            end
            S_FLUSH: begin
                uop = uop_t'(UOP_FLUSH);
                if (cnt != '0)   next_state = S_MAC;
                else if (bias_q) next_state = S_BIAS;
                else if (relu_q) next_state = S_RELU;
                else             next_state = S_OUT;
            end
            S_MAC: begin
                if (op_valid) begin
                    uop       = mk_uop(UOP_MAC, last_beat && !bias_q && !relu_q);
                    pe_x      = op_x;
                    pe_weight = op_w;
                    if (last_beat) begin
                        if (bias_q)      next_state = S_BIAS;
                        else if (relu_q) next_state = S_RELU;
                        else             next_state = S_DRAIN;
                    end
                end
            end
            S_BIAS: begin
                uop        = mk_uop(UOP_BIAS, !relu_q);
                pe_weight  = bias_val_q;
                next_state = relu_q ? S_RELU : S_DRAIN;
            end
            S_RELU: begin
                uop        = mk_uop(UOP_RELU, 1'b1);
                next_state = S_DRAIN;
            end
            S_OUT: begin
                uop        = uop_t'(UOP_OUT_EN);
                next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (pe_out_valid && res_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign pe_flush     = uop.flush;
    assign pe_in_valid  = uop.in_valid;
    assign pe_calc_bias = uop.calc_bias;
    assign pe_calc_relu = uop.calc_relu;
    assign pe_out_en    = uop.out_en;

    assign op_ready  = (state == S_MAC);
    assign res_valid = (state == S_DRAIN) && pe_out_valid;
    assign res_data  = (state == S_DRAIN) ? pe_result : '0;

    // cmd_ready is registered so it stays low while reset is asserted and
    // rises on the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bias_q     <= 1'b0;
            relu_q     <= 1'b0;
            bias_val_q <= '0;
            cmd_ready  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state     <= next_state;
            cmd_ready <= (next_state == S_IDLE);
            if (accept) begin
                cnt        <= cmd_len;
                bias_q     <= cmd_bias;
                relu_q     <= cmd_relu;
                bias_val_q <= cmd_bias_val;
            end else if (state == S_MAC && op_valid) begin
                cnt <= cnt - CNT_W'(1);
            end
            // A command accept clears err even if the pe flags the same cycle.
            if (accept)              err <= 1'b0;
            else if (pe_illegal_uop) err <= 1'b1;
        end
    end

endmodule

// File: doc/pe_seq.md
Name: pe_seq

Overview:
- Micro-op sequencer directly upstream of a single pe compute unit.
- Accepts one dot-product job command and a valid/ready stream of (x, weight) operand pairs.
- Drives the pe control uops: flush, MAC, bias, relu and out_en, in that order.
- Holds the pe result until a downstream valid/ready consumer takes it, and checks the pe illegal_uop flag.

Parameters:
- CNT_W, 16, width of the job MAC-count field.
- Operand and result width is `XLEN from defines.sv; data buses use `DATA_RANGE.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  job command valid
- cmd_ready  out  1  high only in IDLE
- cmd_len  in  CNT_W  number of MAC operations, 0 allowed
- cmd_bias  in  1  add bias after the MACs
- cmd_relu  in  1  apply relu at the end
- cmd_bias_val  in  `XLEN  bias value, captured at command accept
- op_valid  in  1  operand pair valid
- op_ready  out  1  high only in MAC state
- op_x  in  `XLEN  activation
- op_w  in  `XLEN  weight
- pe_x  out  `XLEN  pe x input
- pe_weight  out  `XLEN  pe weight input
- pe_in_valid  out  1  pe in_valid
- pe_flush  out  1  pe flush
- pe_out_en  out  1  pe out_en
- pe_calc_bias  out  1  pe calc_bias
- pe_calc_relu  out  1  pe calc_relu
- pe_result  in  `XLEN  pe result_out
- pe_out_valid  in  1  pe out_valid_r
- pe_illegal_uop  in  1  pe illegal_uop
- res_valid  out  1  result valid to the consumer
- res_data  out  `XLEN  equals pe_result
- res_ready  in  1  consumer ready
- err  out  1  sticky illegal-uop flag

Behaviour:
- Reset (async, rst_n low): state IDLE, counters cleared, all outputs 0 (cmd_ready becomes 1 in IDLE after reset release), err 0. Reset mid-job aborts the job immediately; no resume.
- States: IDLE, FLUSH, MAC, BIAS, RELU, OUT, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: register len, bias, relu and bias_val; clear err; go to FLUSH.
- FLUSH (1 cycle):
  - pe_flush=1, all other uop bits 0.
  - Next state is the first enabled of MAC (len>0), BIAS, RELU; otherwise OUT.
- MAC:
  - op_ready=1.
  - When op_valid: pe_in_valid=1, pe_x=op_x, pe_weight=op_w, remaining count decrements.
  - When !op_valid: all uop bits 0 (pe holds); count unchanged.
  - Leave on the last accepted pair.
- BIAS (1 cycle): pe_in_valid=1, pe_calc_bias=1, pe_weight=bias_val, pe_x=0.
- RELU (1 cycle): pe_calc_relu=1, pe_in_valid=0.
- OUT (1 cycle): only when len=0, !bias and !relu. Issues out_en alone.
- out_en rule: pe_out_en=1 exactly on the last issued uop of the job (last MAC beat, BIAS, RELU or OUT). It is never combined with flush.
- Illegal combinations are never generated: calc_bias only with in_valid=1; calc_relu only with in_valid=0; never both together.
- DRAIN:
  - Uop bits all 0, so the pe holds result and out_valid.
  - res_valid = pe_out_valid; res_data = pe_result.
  - On res_valid && res_ready, go to IDLE.
  - res_valid held while res_ready=0; data stays stable.
- Latency: command accepted at cycle T → FLUSH at T+1 → first MAC at T+2. With no stalls, pe_out_valid and res_valid rise 1 cycle after the out_en uop.
- Unused data buses drive 0 in every state that does not use them.
- err: set on any cycle pe_illegal_uop=1; sticky until the next command accept, which has priority over a same-cycle set.
- Arithmetic is owned by the pe. Signed wrap at `XLEN; no saturation.
- A new command is accepted no earlier than the cycle after a DRAIN handshake.

Decomposition:
- Add a pe_seq_pkg, or entries in defines.sv, containing:
  - the state enum;
  - a uop struct {flush, in_valid, calc_bias, calc_relu, out_en};
  - a localparam with the 5-bit uop encodings shared with pe.
- No sub-module. A top-level pe_lane wrapper instantiating pe_seq plus pe is natural for test.

Test Plan:
- Basic MAC+bias+relu, no stalls: len=3, pairs (3,4),(-2,5),(1,1), bias -10, relu=1 → res_data=0; res_valid at T+7 (FLUSH T+1, MAC T+2..T+4, BIAS T+5, RELU T+6).
- Same job with relu=0 → res_data=-7 (0xFFFFFFF9 at XLEN=32), res_valid at T+6.
- Operand stalls: len=2, (7,6) then op_valid low 3 cycles then (2,-1), no bias or relu → res_data=40. During the gap all uop bits are 0; out_en is on the second MAC beat only.
- Backpressure: res_ready=0 for 5 cycles → res_valid and res_data stable, cmd_ready=0. res_ready=1 → IDLE next cycle and cmd_ready=1.
- Degenerate job: len=0, no bias, no relu → FLUSH, then OUT (out_en only), then res_data=0. Next job (len=1, (5,5)) gives 25, proving flush clears the old result.
- Reset mid-MAC (rst_n low after 1 of 3 pairs) → all outputs 0 immediately, IDLE after release. A new job gives a correct result. An injected pe_illegal_uop=1 sets err until the next command accept.
